bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_updown_counter.sv | 75 +++++++
 tb/tb_bcd_updown_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: prescaled BCD (0..9) up/down counter with clear, load and carry.
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   en             count/prescale enable
//   up             direction, 1 = up, 0 = down
//   clr            synchronous clear (highest priority)
//   load           synchronous parallel load from D8..D1
//   D1,D2,D4,D8    load data, BCD weights 1/2/4/8
//   A1,A2,A4,A8    registered BCD count, weights 1/2/4/8
//   tc             combinational terminal count, high in the cycle a wrap step occurs
//   load_err       registered one-cycle pulse after a non-BCD load value
module bcd_updown_counter #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic up,
    input  logic clr,
    input  logic load,
    input  logic D1,
    input  logic D2,
    input  logic D4,
    input  logic D8,
    output logic A1,
    output logic A2,
    output logic A4,
    output logic A8,
    output logic tc,
    output logic load_err
);
    logic [3:0] count;
    logic [3:0] nxt;
    logic [3:0] d;
    logic       d_ok;
    logic       step;

    assign d    = {D8, D4, D2, D1};
    assign d_ok = d <= 4'd9;
    assign nxt  = up ? ((count == 4'd9) ? 4'd0 : count + 4'd1)
                     : ((count == 4'd0) ? 4'd9 : count - 4'd1);

    generate
        if (DIV == 1) begin : g_nopre
            assign step = en;
        end else begin : g_pre
            localparam int PW = $clog2(DIV);
            logic [PW-1:0] pre;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pre <= '0;
                else if (clr || load) pre <= '0;
                else if (en) pre <= (pre == PW'(DIV - 1)) ? '0 : pre + 1'b1;
            end
            assign step = en && (pre == PW'(DIV - 1));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 4'd0;
            load_err <= 1'b0;
        end else begin
            load_err <= !clr && load && !d_ok;
            if (clr) count <= 4'd0;
            else if (load) count <= d_ok ? d : 4'd0;
            else if (step) count <= nxt;
        end
    end

    // rst_n gates tc so it reads 0 while reset is held even though count==0
    assign tc = rst_n && step && !clr && !load && (up ? count == 4'd9 : count == 4'd0);

    assign {A8, A4, A2, A1} = count;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: checks DIV=1 and DIV=3 counters against a mod-10 reference model.
module tb_bcd_updown_counter;
    logic clk = 1'b0;
    logic rst_n, en, up, clr, load;
    logic [3:0] dv;
    logic [3:0] a_out [2];
    logic tc_out [2];
    logic le_out [2];
    int m_c [2];
    int m_p [2];
    int m_e [2];
    bit live = 1'b0;
    int checks = 0;
    int errors = 0;

    localparam logic [7:0] VEC [16] = '{
        8'b1100_0000, 8'b1100_0000, 8'b1000_0000, 8'b1000_0000,
        8'b0100_0000, 8'b1001_1001, 8'b1100_0000, 8'b1100_0000,
        8'b1000_0000, 8'b1000_0000, 8'b1000_0000, 8'b0101_1111,
        8'b1110_0011, 8'b1000_0000, 8'b1000_0000, 8'b1100_0000
    };

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .D1(dv[0]), .D2(dv[1]), .D4(dv[2]), .D8(dv[3]),
        .A1(a_out[0][0]), .A2(a_out[0][1]), .A4(a_out[0][2]), .A8(a_out[0][3]),
        .tc(tc_out[0]), .load_err(le_out[0])
    );

    bcd_updown_counter #(.DIV(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .D1(dv[0]), .D2(dv[1]), .D4(dv[2]), .D8(dv[3]),
        .A1(a_out[1][0]), .A2(a_out[1][1]), .A4(a_out[1][2]), .A8(a_out[1][3]),
        .tc(tc_out[1]), .load_err(le_out[1])
    );

    function automatic int div_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [8:0] decode(logic [3:0] a);
        logic [8:0] o = '0;
        for (int k = 1; k <= 9; k++) o[k-1] = (a == 4'(k));
        return o;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_c[i] = 0;
                m_p[i] = 0;
                m_e[i] = 0;
            end else begin
                m_e[i] = 0;
                if (clr) begin
                    m_c[i] = 0;
                    m_p[i] = 0;
                end else if (load) begin
                    m_c[i] = (int'(dv) < 10) ? int'(dv) : 0;
                    m_e[i] = (int'(dv) > 9) ? 1 : 0;
                    m_p[i] = 0;
                end else if (en) begin
                    if (m_p[i] == div_of(i) - 1) begin
                        m_p[i] = 0;
                        m_c[i] = up ? (m_c[i] + 1) % 10 : (m_c[i] + 9) % 10;
                    end else begin
                        m_p[i] = m_p[i] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 2; i++) begin
                bit exp_tc;
                logic [8:0] dec;
                exp_tc = rst_n && en && !clr && !load && (m_p[i] == div_of(i) - 1)
                         && (up ? m_c[i] == 9 : m_c[i] == 0);
                dec = decode(a_out[i]);
                chk(i == 0 ? "cmp_a_div1" : "cmp_a_div3", 8'(a_out[i]), 8'(m_c[i]));
                chk(i == 0 ? "cmp_tc_div1" : "cmp_tc_div3", 8'(tc_out[i]), 8'(exp_tc));
                chk(i == 0 ? "cmp_lerr_div1" : "cmp_lerr_div3", 8'(le_out[i]), 8'(m_e[i]));
                chk(i == 0 ? "dec_onehot_div1" : "dec_onehot_div3", 8'($countones(dec)),
                    8'(m_c[i] != 0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int exp_dn [3] = '{9, 8, 7};
        logic [7:0] v;
        rst_n = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; dv = 4'd0;
        #1 rst_n = 1'b0;
        live = 1'b1;
        tick();
        tick();
        en = 1'b1; up = 1'b0;
        #1;
        chk("rst_a", 8'(a_out[0]), 8'd0);
        chk("rst_tc_gated", 8'(tc_out[0]), 8'd0);
        chk("rst_lerr", 8'(le_out[0]), 8'd0);
        up = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("up_seq", 8'(a_out[0]), 8'(exp_up[k]));
            chk("up_tc", 8'(tc_out[0]), 8'(exp_up[k] == 9));
        end
        rst_n = 1'b0; up = 1'b0;
        #1;
        chk("async_rst_a", 8'(a_out[0]), 8'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("dn_tc_at0", 8'(tc_out[0]), 8'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("dn_seq", 8'(a_out[0]), 8'(exp_dn[k]));
            chk("dn_tc", 8'(tc_out[0]), 8'd0);
        end
        rst_n = 1'b0; up = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("div3_e1", 8'(a_out[1]), 8'd0);
        tick();
        chk("div3_e2", 8'(a_out[1]), 8'd0);
        tick();
        chk("div3_e3", 8'(a_out[1]), 8'd1);
        tick();
        chk("div3_e4", 8'(a_out[1]), 8'd1);
        en = 1'b0;
        tick();
        tick();
        chk("div3_frozen", 8'(a_out[1]), 8'd1);
        chk("div3_frozen_tc", 8'(tc_out[1]), 8'd0);
        en = 1'b1;
        tick();
        chk("div3_resume1", 8'(a_out[1]), 8'd1);
        tick();
        chk("div3_resume2", 8'(a_out[1]), 8'd2);
        load = 1'b1; dv = 4'b0110;
        tick();
        chk("load6_a", 8'(a_out[0]), 8'd6);
        chk("load6_a_div3", 8'(a_out[1]), 8'd6);
        chk("load6_lerr", 8'(le_out[0]), 8'd0);
        dv = 4'b1101;
        tick();
        chk("load13_a", 8'(a_out[0]), 8'd0);
        chk("load13_lerr", 8'(le_out[0]), 8'd1);
        load = 1'b0;
        tick();
        chk("lerr_one_cycle", 8'(le_out[0]), 8'd0);
        clr = 1'b1; load = 1'b1; dv = 4'b0101;
        tick();
        chk("clr_over_load", 8'(a_out[0]), 8'd0);
        chk("clr_lerr", 8'(le_out[0]), 8'd0);
        clr = 1'b0; dv = 4'd7; up = 1'b1;
        tick();
        load = 1'b0;
        chk("load7", 8'(a_out[0]), 8'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("midcycle_rst_a", 8'(a_out[0]), 8'd0);
        chk("midcycle_rst_tc", 8'(tc_out[0]), 8'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("after_rst_first_edge", 8'(a_out[0]), 8'd1);
        repeat (20) tick();
        chk("freerun20", 8'(a_out[0]), 8'd1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) begin
                v = VEC[k];
                {en, up, clr, load, dv} = v;
                tick();
            end
        end
        en = 1'b0; clr = 1'b0; load = 1'b0;
        tick();
        live = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
